decode_stage: RTL and testbench

- IF/ID pipeline register plus RV32I decoder, directly downstream of the instruction fetch unit.
- Accepts (pc, instruction) pairs from fetch over a valid/ready handshake.
- Decodes the instruction into register indices, a sign-extended immediate, an ALU op and class flags, and presents the result one cycle later to execute.
- A two-entry output/skid buffer gives full throughput under downstream backpressure; flush discards in-flight entries on branch redirect.

---
 rtl/decode_stage.sv | 235 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: IF/ID pipeline register with an RV32I decoder.
//
// Takes (pc, instr) pairs from fetch over valid/ready. It decodes them
// combinationally and registers the decoded bundle. A two-entry store
// (OUT + SKID) keeps full throughput under backpressure. if_ready depends
// only on registered state.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   flush               drop all buffered bundles and any same-cycle input
//   if_valid/if_ready   fetch handshake; if_pc, if_instr payload
//   id_valid/id_ready   execute handshake
//   id_*                decoded bundle: pc, raw instr, rs1/rs2/rd, imm,
//                       funct3, alu_op, class flags, reg_write, illegal
//
// Optional: define DECODE_RV32M_EN to accept the RV32M OP encodings
// (funct7 = 0x01). These produce alu_op 16..23.
module decode_stage #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_TAG = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic [XLEN-1:0] id_imm,
  output logic [2:0]      id_funct3,
  output logic [4:0]      id_alu_op,
  output logic            id_is_load,
  output logic            id_is_store,
  output logic            id_is_branch,
  output logic            id_is_jal,
  output logic            id_is_jalr,
  output logic            id_is_lui,
  output logic            id_is_auipc,
  output logic            id_is_system,
  output logic            id_is_fence,
  output logic            id_reg_write,
  output logic            id_illegal
);
  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111,
                         OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111,
                         OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                         OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011,
                         OPC_OP = 7'b0110011, OPC_FENCE = 7'b0001111,
                         OPC_SYSTEM = 7'b1110011;
  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2,
                         ALU_SLT = 5'd3, ALU_SLTU = 5'd4, ALU_XOR = 5'd5,
                         ALU_SRL = 5'd6, ALU_SRA = 5'd7, ALU_OR = 5'd8,
                         ALU_AND = 5'd9, ALU_PASS = 5'd10;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic [4:0]      alu_op;
    logic is_load, is_store, is_branch, is_jal, is_jalr;
    logic is_lui, is_auipc, is_system, is_fence;
    logic reg_write;
    logic illegal;
  } bundle_t;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc   = if_instr[6:0];
  assign f3    = if_instr[14:12];
  assign f7    = if_instr[31:25];
  assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                  if_instr[30:25], if_instr[11:8], 1'b0};
  assign imm_u = {if_instr[31:12], 12'b0};
  assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                  if_instr[20], if_instr[30:21], 1'b0};

  // ALU op shared by OP and OP-IMM; funct7[5] selects SUB only for
  // register-register, but selects SRA for both forms.
  logic [4:0] arith_op;
  always_comb begin
    arith_op = ALU_AND;
    case (f3)
      3'd0:    arith_op = (opc == OPC_OP && f7[5]) ? ALU_SUB : ALU_ADD;
      3'd1:    arith_op = ALU_SLL;
      3'd2:    arith_op = ALU_SLT;
      3'd3:    arith_op = ALU_SLTU;
      3'd4:    arith_op = ALU_XOR;
      3'd5:    arith_op = f7[5] ? ALU_SRA : ALU_SRL;
      3'd6:    arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  bundle_t dec;
  logic    ill, use_rs1, use_rs2, use_rd;

  always_comb begin
    dec        = '0;
    dec.pc     = if_pc;
    dec.instr  = if_instr;
    dec.funct3 = f3;
    ill        = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    use_rd     = 1'b0;
    case (opc)
      OPC_LUI:   begin use_rd = 1'b1; dec.imm = imm_u; dec.alu_op = ALU_PASS; dec.is_lui = 1'b1; end
      OPC_AUIPC: begin use_rd = 1'b1; dec.imm = imm_u; dec.is_auipc = 1'b1; end
      OPC_JAL:   begin use_rd = 1'b1; dec.imm = imm_j; dec.is_jal = 1'b1; end
      OPC_JALR: begin
        use_rd = 1'b1; use_rs1 = 1'b1; dec.imm = imm_i; dec.is_jalr = 1'b1;
        ill = (f3 != 3'd0);
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec.imm = imm_b; dec.is_branch = 1'b1;
        dec.alu_op = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
        ill = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        use_rd = 1'b1; use_rs1 = 1'b1; dec.imm = imm_i; dec.is_load = 1'b1;
        ill = (f3 == 3'd3) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec.imm = imm_s; dec.is_store = 1'b1;
        ill = (f3 > 3'd2);
      end
      OPC_OPIMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1; dec.imm = imm_i; dec.alu_op = arith_op;
        if (f3 == 3'd1)      ill = (f7 != 7'h00);
        else if (f3 == 3'd5) ill = (f7 != 7'h00) && (f7 != 7'h20);
      end
      OPC_OP: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; dec.alu_op = arith_op;
        if (f7 == 7'h20)      ill = !(f3 == 3'd0 || f3 == 3'd5);
        else if (f7 != 7'h00) ill = 1'b1;
`ifdef DECODE_RV32M_EN
        if (f7 == 7'h01) begin
          ill        = 1'b0;
          dec.alu_op = 5'd16 + {2'b00, f3};
        end
`endif
      end
      OPC_FENCE:  begin dec.imm = imm_i; dec.is_fence = 1'b1; end
      OPC_SYSTEM: begin
        dec.imm = imm_i; dec.is_system = 1'b1;
        ill = (if_instr != 32'h0000_0073) && (if_instr != 32'h0010_0073);
      end
      default: ill = 1'b1;
    endcase
    if (if_instr[1:0] != 2'b11 || if_instr == 32'h0 || if_instr == 32'hFFFF_FFFF)
      ill = 1'b1;

    if (ill) begin
      // Illegal words carry only identity fields plus the illegal flag.
      dec         = '0;
      dec.pc      = if_pc;
      dec.instr   = if_instr;
      dec.funct3  = f3;
      dec.illegal = 1'b1;
    end else begin
      dec.rs1       = use_rs1 ? if_instr[19:15] : 5'd0;
      dec.rs2       = use_rs2 ? if_instr[24:20] : 5'd0;
      dec.rd        = use_rd  ? if_instr[11:7]  : 5'd0;
      dec.reg_write = use_rd && (if_instr[11:7] != 5'd0);
    end
  end

  // OUT/SKID store. skid_valid implies id_valid, so the stage behaves as a
  // 2-deep FIFO whose ready is registered.
  bundle_t out_q, skid_q;
  logic    skid_valid;
  logic    acc, cons;

  assign if_ready = !skid_valid;
  assign acc      = if_valid && if_ready && !flush;
  assign cons     = id_valid && id_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid   <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      out_q.pc   <= RESET_PC_TAG;
      skid_q     <= '0;
    end else if (flush) begin
      id_valid   <= 1'b0;
      skid_valid <= 1'b0;
    end else if (cons && skid_valid) begin
      // if_ready is low here, so no accept can coincide with the refill.
      out_q      <= skid_q;
      skid_valid <= 1'b0;
    end else if (acc && (!id_valid || cons)) begin
      out_q    <= dec;
      id_valid <= 1'b1;
    end else if (acc) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end else if (cons) begin
      id_valid <= 1'b0;
    end
  end

  assign id_pc        = out_q.pc;
  assign id_instr     = out_q.instr;
  assign id_rs1       = out_q.rs1;
  assign id_rs2       = out_q.rs2;
  assign id_rd        = out_q.rd;
  assign id_imm       = out_q.imm;
  assign id_funct3    = out_q.funct3;
  assign id_alu_op    = out_q.alu_op;
  assign id_is_load   = out_q.is_load;
  assign id_is_store  = out_q.is_store;
  assign id_is_branch = out_q.is_branch;
  assign id_is_jal    = out_q.is_jal;
  assign id_is_jalr   = out_q.is_jalr;
  assign id_is_lui    = out_q.is_lui;
  assign id_is_auipc  = out_q.is_auipc;
  assign id_is_system = out_q.is_system;
  assign id_is_fence  = out_q.is_fence;
  assign id_reg_write = out_q.reg_write;
  assign id_illegal   = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        reset, flush, if_valid, id_ready;
  logic        if_ready, id_valid;
  logic [31:0] if_pc, if_instr, id_pc, id_instr, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_alu_op;
  logic [2:0]  id_funct3;
  logic id_is_load, id_is_store, id_is_branch, id_is_jal, id_is_jalr;
  logic id_is_lui, id_is_auipc, id_is_system, id_is_fence, id_reg_write, id_illegal;

  decode_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm),
    .id_funct3(id_funct3), .id_alu_op(id_alu_op),
    .id_is_load(id_is_load), .id_is_store(id_is_store), .id_is_branch(id_is_branch),
    .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr), .id_is_lui(id_is_lui),
    .id_is_auipc(id_is_auipc), .id_is_system(id_is_system), .id_is_fence(id_is_fence),
    .id_reg_write(id_reg_write), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit model_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // flags order: load store branch jal jalr lui auipc system fence
  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic [8:0]  flags;
    logic        rw;
    logic        ill;
  } exp_t;

  // Reference decoder: classify by opcode, pick a format letter, then derive
  // register usage and the immediate arithmetically from that format.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int   sw, f3, f7, op;
    byte  fmt;
    bit   ok, arith;
    int   tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    e = '0; sw = $signed(w); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    op = int'(w[6:0]); fmt = "X"; ok = 1'b1; arith = 1'b0;
    case (op)
      'h37: begin fmt = "U"; e.flags = 9'b000001000; e.alu = 5'd10; end
      'h17: begin fmt = "U"; e.flags = 9'b000000100; end
      'h6F: begin fmt = "J"; e.flags = 9'b000100000; end
      'h67: begin fmt = "I"; e.flags = 9'b000010000; ok = (f3 == 0); end
      'h63: begin
        fmt = "B"; e.flags = 9'b001000000; ok = !(f3 == 2 || f3 == 3);
        e.alu = (f3 < 2) ? 5'd1 : (f3 < 6) ? 5'd3 : 5'd4;
      end
      'h03: begin fmt = "I"; e.flags = 9'b100000000; ok = f3 inside {0, 1, 2, 4, 5}; end
      'h23: begin fmt = "S"; e.flags = 9'b010000000; ok = (f3 <= 2); end
      'h13: begin
        fmt = "I"; arith = 1'b1;
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) ok = (f7 == 0 || f7 == 32);
      end
      'h33: begin
        fmt = "R"; arith = 1'b1;
        ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
      end
      'h0F: begin fmt = "F"; e.flags = 9'b000000001; end
      'h73: begin fmt = "F"; e.flags = 9'b000000010; ok = (w == 32'h73 || w == 32'h100073); end
      default: ok = 1'b0;
    endcase
    if (arith) begin
      e.alu = 5'(tab[f3]);
      // SUB and SRA sit one code above ADD and SRL.
      if (f7 == 32 && (f3 == 5 || (f3 == 0 && op == 'h33))) e.alu = e.alu + 5'd1;
    end
`ifdef DECODE_RV32M_EN
    if (op == 'h33 && f7 == 1) begin ok = 1'b1; e.alu = 5'(16 + f3); end
`endif
    if (w[1:0] != 2'b11 || w == 32'h0 || w == 32'hFFFF_FFFF) ok = 1'b0;
    case (fmt)
      "I", "F": e.imm = 32'(sw >>> 20);
      "S": e.imm = 32'((sw >>> 25) * 32 + int'(w[11:7]));
      "B": e.imm = 32'((sw >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
      "U": e.imm = w & 32'hFFFF_F000;
      "J": e.imm = 32'((sw >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
      default: e.imm = 32'h0;
    endcase
    if (fmt inside {"R", "I", "S", "B"}) e.rs1 = w[19:15];
    if (fmt inside {"R", "S", "B"})      e.rs2 = w[24:20];
    if (fmt inside {"R", "I", "U", "J"}) e.rd  = w[11:7];
    e.rw = (e.rd != 5'd0);
    if (!ok) begin e = '0; e.ill = 1'b1; end
    return e;
  endfunction

  // Scoreboard: the stage is a 2-deep FIFO with registered ready.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t q[$];
  exp_t ex;
  bit   rdy, pop, push;

  always @(negedge clk) begin
    if (model_on) begin
      chk("sb_id_valid", 32'(id_valid), 32'(q.size() != 0));
      chk("sb_if_ready", 32'(if_ready), 32'(q.size() < 2));
      if (q.size() != 0 && id_valid) begin
        ex = model(q[0].instr);
        chk("sb_pc", id_pc, q[0].pc);
        chk("sb_instr", id_instr, q[0].instr);
        chk("sb_funct3", 32'(id_funct3), 32'(q[0].instr[14:12]));
        chk("sb_flags", 32'({id_is_load, id_is_store, id_is_branch, id_is_jal, id_is_jalr,
                             id_is_lui, id_is_auipc, id_is_system, id_is_fence}), 32'(ex.flags));
        chk("sb_reg_write", 32'(id_reg_write), 32'(ex.rw));
        chk("sb_illegal", 32'(id_illegal), 32'(ex.ill));
        if (!ex.ill) begin
          chk("sb_rs1", 32'(id_rs1), 32'(ex.rs1));
          chk("sb_rs2", 32'(id_rs2), 32'(ex.rs2));
          chk("sb_rd", 32'(id_rd), 32'(ex.rd));
          chk("sb_imm", id_imm, ex.imm);
          chk("sb_alu_op", 32'(id_alu_op), 32'(ex.alu));
        end
      end
      // Effect of the coming rising edge.
      if (reset || flush) q.delete();
      else begin
        rdy  = (q.size() < 2);
        pop  = (q.size() != 0) && id_ready;
        push = if_valid && rdy;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back('{if_pc, if_instr});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] pc, input logic [31:0] instr);
    if_pc = pc; if_instr = instr;
    tick();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    if_pc = 32'h0; if_instr = 32'h0;
    tick();
    model_on = 1'b1;
    tick();
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd1);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_imm", id_imm, 32'h0);
    chk("rst_reg_write", 32'(id_reg_write), 32'd0);

    // Back-to-back stream.
    reset = 1'b0; if_valid = 1'b1; id_ready = 1'b1;
    feed(32'h0, 32'h0050_0093);
    chk("addi_valid", 32'(id_valid), 32'd1);
    chk("addi_rd", 32'(id_rd), 32'd1);
    chk("addi_imm", id_imm, 32'd5);
    chk("addi_alu", 32'(id_alu_op), 32'd0);
    chk("addi_rw", 32'(id_reg_write), 32'd1);
    feed(32'h4, 32'h4020_8133);
    chk("sub_valid", 32'(id_valid), 32'd1);
    chk("sub_pc", id_pc, 32'h4);
    chk("sub_alu", 32'(id_alu_op), 32'd1);
    chk("sub_rs1", 32'(id_rs1), 32'd1);
    chk("sub_rs2", 32'(id_rs2), 32'd2);
    if_valid = 1'b0; tick();
    chk("drain_valid", 32'(id_valid), 32'd0);

    // Backpressure: three offered, two taken.
    id_ready = 1'b0; if_valid = 1'b1;
    feed(32'h8, 32'h0070_0193);
    feed(32'hC, 32'h0020_C233);
    chk("bp_ready_low", 32'(if_ready), 32'd0);
    chk("bp_head_pc", id_pc, 32'h8);
    feed(32'h10, 32'h0080_A283);
    chk("bp_hold_pc", id_pc, 32'h8);
    id_ready = 1'b1; tick();
    chk("bp_second_pc", id_pc, 32'hC);
    chk("bp_ready_back", 32'(if_ready), 32'd1);
    tick();
    chk("bp_third_pc", id_pc, 32'h10);
    if_valid = 1'b0; tick();
    chk("bp_empty", 32'(id_valid), 32'd0);

    // Flush with both entries full and an input offered.
    id_ready = 1'b0; if_valid = 1'b1;
    feed(32'h20, 32'h0010_0293);
    feed(32'h24, 32'h0020_0313);
    if_pc = 32'h28; if_instr = 32'h0030_0393; flush = 1'b1; tick();
    flush = 1'b0; if_valid = 1'b0;
    chk("flush_valid", 32'(id_valid), 32'd0);
    chk("flush_ready", 32'(if_ready), 32'd1);
    id_ready = 1'b1; tick();
    chk("flush_absent", 32'(id_valid), 32'd0);
    // Flush while ready: the same-cycle input must be dropped.
    if_valid = 1'b1; flush = 1'b1; feed(32'h2C, 32'h0040_0413);
    flush = 1'b0; if_valid = 1'b0; tick();
    chk("flush_drop_input", 32'(id_valid), 32'd0);

    // Decode table, one per cycle.
    if_valid = 1'b1; id_ready = 1'b1;
    feed(32'h100, 32'hFE00_0EE3);
    chk("beq_imm", id_imm, 32'hFFFF_FFFC);
    chk("beq_branch", 32'(id_is_branch), 32'd1);
    chk("beq_alu", 32'(id_alu_op), 32'd1);
    feed(32'h104, 32'h1234_50B7);
    chk("lui_imm", id_imm, 32'h1234_5000);
    chk("lui_alu", 32'(id_alu_op), 32'd10);
    feed(32'h108, 32'h0000_0000);
    chk("zero_illegal", 32'(id_illegal), 32'd1);
    chk("zero_rw", 32'(id_reg_write), 32'd0);
    feed(32'h10C, 32'h0000_700B);
    chk("custom_illegal", 32'(id_illegal), 32'd1);
    chk("custom_rw", 32'(id_reg_write), 32'd0);
    feed(32'h110, 32'h0220_8133);
`ifdef DECODE_RV32M_EN
    chk("mul_alu", 32'(id_alu_op), 32'd16);
    chk("mul_illegal", 32'(id_illegal), 32'd0);
    chk("mul_rw", 32'(id_reg_write), 32'd1);
`else
    chk("mul_illegal", 32'(id_illegal), 32'd1);
    chk("mul_rw", 32'(id_reg_write), 32'd0);
`endif
    feed(32'h114, 32'h0FF0_000F);
    chk("fence_flag", 32'(id_is_fence), 32'd1);
    chk("fence_rw", 32'(id_reg_write), 32'd0);
    feed(32'h118, 32'h0000_0073);
    feed(32'h11C, 32'h0010_0073);
    feed(32'h120, 32'h4010_D093);
    chk("srai_alu", 32'(id_alu_op), 32'd7);
    feed(32'h124, 32'h2010_D093);
    chk("srai_bad", 32'(id_illegal), 32'd1);
    feed(32'h128, 32'h0080_00EF);
    chk("jal_imm", id_imm, 32'h8);
    feed(32'h12C, 32'h0020_A423);
    chk("sw_imm", id_imm, 32'h8);
    feed(32'h130, 32'h0020_E463);
    feed(32'h134, 32'h0000_8067);
    feed(32'h138, 32'h0000_B083);
    feed(32'h13C, 32'hFFFF_FFFF);
    feed(32'h140, 32'h0000_1517);
    feed(32'h144, 32'hFFF0_A113);
    if_valid = 1'b0; tick();

    // Reset mid-stream while stalled.
    id_ready = 1'b0; if_valid = 1'b1;
    feed(32'h200, 32'h0050_0093);
    chk("mid_valid", 32'(id_valid), 32'd1);
    reset = 1'b1; feed(32'h204, 32'h0060_0113);
    chk("mid_rst_valid", 32'(id_valid), 32'd0);
    chk("mid_rst_pc", id_pc, 32'h0);
    chk("mid_rst_ready", 32'(if_ready), 32'd1);
    reset = 1'b0; if_valid = 1'b0; tick();
    chk("mid_rst_stays", 32'(id_valid), 32'd0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
